// File: rtl/stoat_wb_responder.sv
// Pipelined Wishbone memory responder: byte-lane writes, fixed-latency in-order
// acks with a bounded number of outstanding requests.
module stoat_wb_responder #(
    parameter int MEM_WORDS   = 1024,
    parameter int ACK_LATENCY = 2,
    parameter int MAX_PENDING = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cyc,
    input  logic        i_stb,
    input  logic        i_we,
    input  logic [3:0]  i_sel,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data_mosi,
    input  logic        i_bp,
    output logic        o_stall,
    output logic        o_ack,
    output logic [31:0] o_data_miso
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    logic [AW-1:0]          w_idx;
    logic [31:0]            w_mem_word;
    logic                   w_accept;
    logic                   w_ack;
    logic [PW-1:0]          w_pending_next;
    logic                   w_unused_addr;

    logic                   r_cyc_q;
    logic [PW-1:0]          r_pending;
    logic [ACK_LATENCY-1:0] r_valid;
    logic [31:0]            r_data [ACK_LATENCY];

    assign w_idx         = i_addr[AW+1:2];
    assign w_unused_addr = &{1'b0, i_addr[31:AW+2], i_addr[1:0]};

    // Stall only looks at registered state plus i_cyc/i_bp, so an ack in the
    // same cycle cannot release a full pipeline until the following cycle.
    assign o_stall  = i_cyc & r_cyc_q & ((r_pending == PEND_MAX) | i_bp);
    assign w_accept = i_cyc & i_stb & ~o_stall;
    assign w_ack    = r_valid[ACK_LATENCY-1];

    assign o_ack       = w_ack;
    assign o_data_miso = r_data[ACK_LATENCY-1];

    // One storage array per byte lane keeps the partial writes independent.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_mem [MEM_WORDS];

        always_ff @(posedge i_clk) begin
            if (w_accept && i_we && i_sel[gi]) begin
                r_mem[w_idx] <= i_data_mosi[8*gi +: 8];
            end
        end

        assign w_mem_word[8*gi +: 8] = r_mem[w_idx];
    end

    always_comb begin
        w_pending_next = r_pending;
        if (w_accept && !w_ack) begin
            w_pending_next = r_pending + PW'(1);
        end else if (!w_accept && w_ack) begin
            w_pending_next = r_pending - PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cyc_q   <= 1'b0;
            r_pending <= '0;
            r_valid   <= '0;
            for (int k = 0; k < ACK_LATENCY; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_cyc_q <= i_cyc;
            if (!i_cyc) begin
                // Bus cycle dropped: everything in flight is abandoned.
                r_pending <= '0;
                r_valid   <= '0;
                for (int k = 0; k < ACK_LATENCY; k++) begin
                    r_data[k] <= '0;
                end
            end else begin
                r_pending  <= w_pending_next;
                r_valid[0] <= w_accept;
                r_data[0]  <= (w_accept && !i_we) ? w_mem_word : 32'h0;
                for (int k = 1; k < ACK_LATENCY; k++) begin
                    r_valid[k] <= r_valid[k-1];
                    r_data[k]  <= r_data[k-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_stoat_wb_responder.sv
// Directed bench: DUT a uses default latency 2, DUT b uses latency 8.
// Inputs change just after a rising edge; outputs are checked on the falling edge.
module tb_stoat_wb_responder;
    logic        clk;
    logic        rst_n;
    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic [3:0]  sel   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdat  [2];
    logic        bp    [2];
    logic        stall [2];
    logic        ack   [2];
    logic [31:0] rdat  [2];

    int n_checks = 0;
    int n_pass   = 0;

    stoat_wb_responder dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_cyc(cyc[0]), .i_stb(stb[0]), .i_we(we[0]),
        .i_sel(sel[0]), .i_addr(addr[0]), .i_data_mosi(wdat[0]), .i_bp(bp[0]),
        .o_stall(stall[0]), .o_ack(ack[0]), .o_data_miso(rdat[0])
    );

    stoat_wb_responder #(.MEM_WORDS(256), .ACK_LATENCY(8), .MAX_PENDING(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_cyc(cyc[1]), .i_stb(stb[1]), .i_we(we[1]),
        .i_sel(sel[1]), .i_addr(addr[1]), .i_data_mosi(wdat[1]), .i_bp(bp[1]),
        .o_stall(stall[1]), .o_ack(ack[1]), .o_data_miso(rdat[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One cycle: drive inputs, check outputs mid-cycle, advance past the next edge.
    task automatic vec(input int d, input string tag,
                       input logic c, input logic s, input logic w,
                       input logic [3:0] sl, input logic [31:0] a, input logic [31:0] dt,
                       input logic b, input logic e_stall, input logic e_ack,
                       input logic [31:0] e_data, input int e_pend);
        logic [31:0] pend;
        cyc[d] = c; stb[d] = s; we[d] = w; sel[d] = sl; addr[d] = a; wdat[d] = dt; bp[d] = b;
        @(negedge clk);
        $display("%0t %s dut%0d cyc=%0b stb=%0b we=%0b addr=%h stall=%0b ack=%0b data=%h",
                 $time, tag, d, c, s, w, a, stall[d], ack[d], rdat[d]);
        check_eq({tag, ".stall"}, 32'(stall[d]), 32'(e_stall));
        check_eq({tag, ".ack"}, 32'(ack[d]), 32'(e_ack));
        check_eq({tag, ".data"}, rdat[d], e_data);
        if (e_pend >= 0) begin
            pend = (d == 0) ? 32'(dut_a.r_pending) : 32'(dut_b.r_pending);
            check_eq({tag, ".pending"}, pend, 32'(e_pend));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        c, s, w;
        logic [31:0] a, dt, e_data;
        logic        e_stall, e_ack;
        int          e_pend;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 0; stb[d] = 0; we[d] = 0; sel[d] = 0; addr[d] = 0; wdat[d] = 0; bp[d] = 0;
        end
        @(posedge clk);
        #1;

        // Reset: outputs quiet even with a cycle requested.
        vec(0, "rst0", 1, 1, 0, 4'hF, 32'h10, 0, 1, 0, 0, 32'h0, 0);
        vec(0, "rst1", 1, 1, 0, 4'hF, 32'h10, 0, 1, 0, 0, 32'h0, 0);
        rst_n = 1'b1;
        vec(0, "idle", 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0);

        // Write then read, latency 2.
        vec(0, "wr10", 1, 1, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0, -1);
        vec(0, "rd10", 1, 1, 0, 4'hF, 32'h10, 0, 0, 0, 0, 32'h0, 1);
        vec(0, "wack", 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 1, 32'h0, 2);
        vec(0, "rack", 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 1, 32'hDEADBEEF, -1);
        vec(0, "end1", 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0);

        // Byte-lane merge, then aliased read of the same word.
        vec(0, "wr20", 1, 1, 1, 4'hF, 32'h20, 32'h11223344, 0, 0, 0, 32'h0, -1);
        vec(0, "wr20p", 1, 1, 1, 4'b0101, 32'h20, 32'hAABBCCDD, 0, 0, 0, 32'h0, -1);
        vec(0, "rd20", 1, 1, 0, 4'hF, 32'h20, 0, 0, 0, 1, 32'h0, -1);
        vec(0, "wack2", 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 1, 32'h0, -1);
        vec(0, "merge", 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 1, 32'h11BB33DD, -1);
        vec(0, "alias", 1, 1, 0, 4'hF, 32'h1023, 0, 0, 0, 0, 32'h0, -1);
        vec(0, "gap", 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0, -1);
        vec(0, "aliasack", 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 1, 32'h11BB33DD, -1);
        vec(0, "end2", 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0);

        // Backpressure holds off a request until released.
        vec(0, "bp0", 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0, -1);
        vec(0, "bp1", 1, 1, 0, 4'hF, 32'h10, 0, 1, 1, 0, 32'h0, -1);
        vec(0, "bprel", 1, 1, 0, 4'hF, 32'h10, 0, 0, 0, 0, 32'h0, -1);
        vec(0, "bpgap", 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0, -1);
        vec(0, "bpack", 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 1, 32'hDEADBEEF, -1);
        vec(0, "end3", 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0);

        // Six back-to-back reads alternating 0x10/0x20; acks stream two cycles behind.
        for (int k = 1; k <= 9; k++) begin
            c = (k <= 8); s = (k <= 6);
            a = (k % 2 == 1) ? 32'h10 : 32'h20;
            e_ack = (k >= 3 && k <= 8);
            e_data = !e_ack ? 32'h0 : ((k % 2 == 1) ? 32'hDEADBEEF : 32'h11BB33DD);
            e_pend = (k >= 3 && k <= 6) ? 2 : -1;
            vec(0, $sformatf("burst%0d", k), c, s, 0, 4'hF, a, 0, 0, 0, e_ack, e_data, e_pend);
        end

        // Latency 8: four accepted, fifth stalls until the cycle after the first ack.
        for (int k = 1; k <= 19; k++) begin
            c = (k != 19); s = (k <= 10); w = 1;
            a = 0; dt = 0;
            if (k <= 4) begin
                a = 32'(32'h40 + 4 * k); dt = 32'(32'hA0000000 + k);
            end else if (k <= 10) begin
                a = 32'h54; dt = 32'hA0000005;
            end
            e_stall = (k >= 5 && k <= 9);
            e_ack = k inside {9, 10, 11, 12, 18};
            e_pend = (k >= 5 && k <= 9) ? 4 : ((k == 10) ? 3 : -1);
            vec(1, $sformatf("full%0d", k), c, s, w, 4'hF, a, dt, 0, e_stall, e_ack, 32'h0, e_pend);
        end

        // Abort with three writes in flight; stb without cyc is ignored.
        for (int k = 1; k <= 24; k++) begin
            c = 1; s = 0; w = 0; a = 0; dt = 0; e_ack = 0; e_data = 0; e_pend = -1;
            if (k <= 3) begin
                s = 1; w = 1; a = 32'(32'h60 + 4 * (k - 1)); dt = 32'(32'h13570000 + k);
            end else if (k == 4) begin
                c = 0; s = 1; w = 1; a = 32'h60; dt = 32'hFFFFFFFF;
            end else if (k >= 13 && k <= 15) begin
                s = 1; a = 32'(32'h60 + 4 * (k - 13));
            end
            if (k >= 5 && k <= 12) e_pend = 0;
            if (k >= 21 && k <= 23) begin
                e_ack = 1; e_data = 32'(32'h13570000 + (k - 20));
            end
            if (k == 24) c = 0;
            vec(1, $sformatf("abort%0d", k), c, s, w, 4'hF, a, dt, 0, 0, e_ack, e_data, e_pend);
        end

        // Reset with two writes in flight: no acks, written data survives.
        vec(0, "pre0", 1, 1, 1, 4'hF, 32'h30, 32'h5A5A1234, 0, 0, 0, 32'h0, -1);
        vec(0, "pre1", 1, 1, 1, 4'hF, 32'h34, 32'h0BADF00D, 0, 0, 0, 32'h0, -1);
        rst_n = 1'b0;
        vec(0, "inrst0", 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
        vec(0, "inrst1", 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
        rst_n = 1'b1;
        vec(0, "post0", 1, 1, 0, 4'hF, 32'h30, 0, 0, 0, 0, 32'h0, 0);
        vec(0, "post1", 1, 1, 0, 4'hF, 32'h34, 0, 0, 0, 0, 32'h0, 1);
        vec(0, "post2", 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 1, 32'h5A5A1234, -1);
        vec(0, "post3", 1, 0, 0, 4'h0, 32'h0, 0, 0, 0, 1, 32'h0BADF00D, -1);
        vec(0, "post4", 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
